serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder built around the existing single-bit `full_adder` cell. It accepts two operands and a carry-in on a start strobe, then streams them LSB-first through one `full_adder` with a registered carry, one bit per clock. It presents the registered sum and carry-out with a one-cycle done pulse. It is the sequential companion to the ripple 8-bit adder: it needs one adder cell plus shift registers instead of WIDTH cells.

---
 rtl/serial_adder_pkg.sv | 9 +
 rtl/serial_adder_if.sv | 13 +
 rtl/serial_adder_full_adder.sv | 11 +
 rtl/serial_adder.sv | 84 ++++++++
 tb/tb_serial_adder.sv | 136 +++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding and default operand width for the bit-serial adder.
package serial_adder_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/start request and registered result bundle of the bit-serial adder.
interface serial_adder_if import serial_adder_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
  logic             SA_start;
  logic [WIDTH-1:0] SA_a;
  logic [WIDTH-1:0] SA_b;
  logic             SA_cin;
  logic             SA_busy;
  logic             SA_done;
  logic [WIDTH-1:0] SA_sum;
  logic             SA_cout;
  modport master (output SA_start, SA_a, SA_b, SA_cin, input SA_busy, SA_done, SA_sum, SA_cout);
  modport slave  (input SA_start, SA_a, SA_b, SA_cin, output SA_busy, SA_done, SA_sum, SA_cout);
endinterface

// File: rtl/serial_adder_full_adder.sv
// full_adder: single-bit full adder cell shared by the ripple and serial adders.
module full_adder (
  input  logic FA_in1,
  input  logic FA_in2,
  input  logic FA_cin,
  output logic FA_sum,
  output logic FA_cout
);
  assign FA_sum  = FA_in1 ^ FA_in2 ^ FA_cin;
  assign FA_cout = (FA_in1 & FA_in2) | (FA_cin & (FA_in1 ^ FA_in2));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial WIDTH-bit adder using one full_adder and a registered carry.
module serial_adder import serial_adder_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] sum_sr;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_next;
  logic             last;
  full_adder u_fa (
    .FA_in1 (a_sr[0]),
    .FA_in2 (b_sr[0]),
    .FA_cin (carry),
    .FA_sum (fa_sum),
    .FA_cout(fa_cout)
  );
  // Only WIDTH-1 partial bits need storing; the final bit joins them on the last edge.
  assign sum_next = {fa_sum, sum_sr};
  assign last     = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          busy  <= bus.SA_start;
          state <= bus.SA_start ? RUN : IDLE;
          if (bus.SA_start) begin
            a_sr  <= bus.SA_a;
            b_sr  <= bus.SA_b;
            carry <= bus.SA_cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_next[WIDTH-1:1];
          carry  <= fa_cout;
          cnt    <= last ? cnt : cnt + 1'b1;
          if (last) begin
            sum   <= sum_next;
            cout  <= fa_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
  assign bus.SA_busy = busy;
  assign bus.SA_done = done;
  assign bus.SA_sum  = sum;
  assign bus.SA_cout = cout;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vector table, corner sequences and random operands against A+B+cin.
module tb_serial_adder;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int lat;
  always #5 clk = ~clk;
  serial_adder_if #(.WIDTH(W)) bus();
  serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bus.SA_start = 1'b1;
    bus.SA_a = a;
    bus.SA_b = b;
    bus.SA_cin = cin;
    step();
    bus.SA_start = 1'b0;
    bus.SA_a = W'($urandom);
    bus.SA_b = W'($urandom);
    bus.SA_cin = 1'($urandom);
  endtask
  // Cycles after the accepting edge until done shows; bounded so a stuck DUT still ends.
  task automatic wait_done(input int first, output int l);
    l = first;
    while (!bus.SA_done && l <= W + 4) begin
      chk("busy_in_run", bus.SA_busy, 1);
      step();
      l++;
    end
    chk("done_latency", l, W);
    chk("busy_low_at_done", bus.SA_busy, 0);
  endtask
  task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic [W-1:0] es, input logic ec);
    int l;
    start_op(a, b, cin);
    wait_done(0, l);
    chk({name, "_sum"}, bus.SA_sum, es);
    chk({name, "_cout"}, bus.SA_cout, ec);
  endtask
  initial begin
    bus.SA_start = 1'b0;
    bus.SA_a = '0;
    bus.SA_b = '0;
    bus.SA_cin = 1'b0;
    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'h01, 8'h7F, 1'b1, 8'h81, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_busy", bus.SA_busy, 0);
    chk("reset_done", bus.SA_done, 0);
    chk("reset_sum", bus.SA_sum, 0);
    chk("reset_cout", bus.SA_cout, 0);
    step();
    // Vector 3 is launched in vector 2's done cycle: back-to-back with no idle gap.
    for (int i = 0; i < 7; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);
      if (i != 2) begin
        step();
        chk("done_one_cycle", bus.SA_done, 0);
        chk("idle_after_done", bus.SA_busy, 0);
      end
    end
    start_op(8'h12, 8'h34, 1'b0);
    step();
    step();
    bus.SA_start = 1'b1;
    bus.SA_a = 8'hFF;
    bus.SA_b = 8'hFF;
    step();
    bus.SA_start = 1'b0;
    wait_done(3, lat);
    chk("ignore_start_sum", bus.SA_sum, 8'h46);
    chk("ignore_start_cout", bus.SA_cout, 0);
    repeat (W + 3) begin
      step();
      chk("single_done", bus.SA_done, 0);
      chk("no_requeue", bus.SA_busy, 0);
    end
    start_op(8'h77, 8'h11, 1'b0);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.SA_busy, 0);
    chk("abort_done", bus.SA_done, 0);
    chk("abort_sum", bus.SA_sum, 0);
    chk("abort_cout", bus.SA_cout, 0);
    step();
    rst_n = 1'b1;
    repeat (W + 4) begin
      step();
      chk("no_done_after_abort", bus.SA_done, 0);
      chk("idle_after_abort", bus.SA_busy, 0);
    end
    run_check("post_reset", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W:0]   ref_total;
      repeat ($urandom_range(0, 3)) step();
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      ref_total = (W + 1)'(a) + (W + 1)'(b) + (W + 1)'(cin);
      run_check("rand", a, b, cin, ref_total[W-1:0], ref_total[W]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
